dbg_host_link: RTL and testbench

- Initiator end of the single-byte-command debug serial protocol; the debug responder inside the CPU model serves the other end.
- Takes one command request at a time: command char, optional argument, expected response length.
- Serialises the request onto a byte-stream TX link, then collects the little-endian integer reply from the RX link.
- Also recognises the unsolicited "#BRK"/"#HLT" notifications the CPU side emits when it stops, and reports them as events.

---
 rtl/dbg_host_link.sv | 197 +++++++++++++++++++
 tb/tb_dbg_host_link.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_host_link.sv
// Initiator side of the single-byte-command debug link: sends cmd + LE argument,
// collects the LE reply, and decodes unsolicited "#BRK"/"#HLT" stop notifications.
module dbg_host_link #(
  parameter int TIMEOUT = 50000,
  parameter int DROP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_cmd,
  input  logic [31:0]       req_arg,
  input  logic [2:0]        req_arg_len,
  input  logic [2:0]        req_rsp_len,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_timeout,
  output logic              evt_valid,
  output logic [1:0]        evt_code,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEND_CMD, SEND_ARG, WAIT_RSP, DONE, EVT} state_t;

  state_t        state, state_nxt;
  logic [7:0]    cmd_q;
  logic [31:0]   arg_sh;
  logic [2:0]    arg_left;
  logic [2:0]    rsp_len_q;
  logic [2:0]    rx_idx;
  logic [31:0]   acc, acc_nxt;
  logic [TW-1:0] timer;
  logic [15:0]   evt_buf;
  logic [1:0]    evt_idx;
  logic          timed_out;
  logic          drop;
  logic          rsp_to;
  logic          evt_fire;
  logic [1:0]    evt_code_nxt;

  function automatic logic [2:0] clamp4(input logic [2:0] len);
    return (len > 3'd4) ? 3'd4 : len;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    drop         = 1'b0;
    rsp_to       = 1'b0;
    evt_fire     = 1'b0;
    evt_code_nxt = 2'd3;
    acc_nxt      = acc;
    timed_out    = (timer == TW'(TIMEOUT - 1)) && !rx_valid;
    case (state)
      IDLE: begin
        // Gated by rst_n so the port reads 0 while reset is held.
        req_ready = rst_n;
        if (req_valid) begin
          state_nxt = SEND_CMD;
          drop      = rx_valid;
        end else if (rx_valid) begin
          if (rx_data == 8'h23) state_nxt = EVT;
          else                  drop      = 1'b1;
        end
      end
      SEND_CMD: begin
        tx_valid = 1'b1;
        tx_data  = cmd_q;
        drop     = rx_valid;
        if (tx_ready) begin
          if (arg_left != 3'd0)       state_nxt = SEND_ARG;
          else if (rsp_len_q != 3'd0) state_nxt = WAIT_RSP;
          else                        state_nxt = DONE;
        end
      end
      SEND_ARG: begin
        tx_valid = 1'b1;
        tx_data  = arg_sh[7:0];
        drop     = rx_valid;
        if (tx_ready && arg_left == 3'd1)
          state_nxt = (rsp_len_q != 3'd0) ? WAIT_RSP : DONE;
      end
      WAIT_RSP: begin
        // Reply bytes are raw data; '#' has no special meaning here.
        if (rx_valid) begin
          acc_nxt[{rx_idx[1:0], 3'b000} +: 8] = rx_data;
          if (rx_idx == rsp_len_q - 3'd1) state_nxt = DONE;
        end else if (timed_out) begin
          state_nxt = DONE;
          rsp_to    = 1'b1;
        end
      end
      DONE: begin
        drop      = rx_valid;
        state_nxt = IDLE;
      end
      EVT: begin
        if (rx_valid && evt_idx == 2'd2) begin
          evt_fire  = 1'b1;
          state_nxt = IDLE;
          if ({evt_buf, rx_data} == 24'h42524B)      evt_code_nxt = 2'd1;
          else if ({evt_buf, rx_data} == 24'h484C54) evt_code_nxt = 2'd2;
        end else if (timed_out) begin
          evt_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      arg_sh      <= '0;
      arg_left    <= '0;
      rsp_len_q   <= '0;
      rx_idx      <= '0;
      acc         <= '0;
      timer       <= '0;
      evt_buf     <= '0;
      evt_idx     <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      evt_valid   <= 1'b0;
      evt_code    <= '0;
      drop_cnt    <= '0;
    end else begin
      if (drop && drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
      evt_valid <= evt_fire;
      if (evt_fire) evt_code <= evt_code_nxt;
      // Result registers load on the edge that enters DONE, so they line up with rsp_valid.
      if (state_nxt == DONE && state != DONE) begin
        rsp_data    <= acc_nxt;
        rsp_timeout <= rsp_to;
      end
      case (state)
        IDLE: begin
          timer <= '0;
          if (req_valid) begin
            cmd_q     <= req_cmd;
            arg_sh    <= req_arg;
            arg_left  <= clamp4(req_arg_len);
            rsp_len_q <= clamp4(req_rsp_len);
            acc       <= '0;
            rx_idx    <= '0;
          end else if (rx_valid) begin
            evt_idx <= '0;
          end
        end
        SEND_ARG: begin
          timer <= '0;
          if (tx_ready) begin
            arg_sh   <= arg_sh >> 8;
            arg_left <= arg_left - 3'd1;
          end
        end
        WAIT_RSP: begin
          acc <= acc_nxt;
          if (rx_valid) begin
            rx_idx <= rx_idx + 3'd1;
            timer  <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        EVT: begin
          if (rx_valid) begin
            evt_buf <= {evt_buf[7:0], rx_data};
            evt_idx <= evt_idx + 2'd1;
            timer   <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: timer <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_host_link.sv
// Directed scoreboard bench for dbg_host_link: expected TX bytes, replies and
// events are queued as stimulus is applied and checked as the DUT emits them.
module tb_dbg_host_link;

  localparam int TIMEOUT = 20;
  localparam int DROP_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [7:0]        req_cmd = 8'h00;
  logic [31:0]       req_arg = 32'h0;
  logic [2:0]        req_arg_len = 3'd0;
  logic [2:0]        req_rsp_len = 3'd0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_timeout;
  logic              evt_valid;
  logic [1:0]        evt_code;
  logic [DROP_W-1:0] drop_cnt;

  dbg_host_link #(.TIMEOUT(TIMEOUT), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_arg(req_arg), .req_arg_len(req_arg_len), .req_rsp_len(req_rsp_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .evt_valid(evt_valid), .evt_code(evt_code), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rsp_count = 0, evt_count = 0;
  int last_hs_cyc = 0, last_rsp_cyc = 0, last_evt_cyc = 0, rsp_gap = 0;
  int exp_drop = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_tx = 8'h00;
  logic [7:0]  tx_q[$];
  logic [32:0] rsp_q[$];
  logic [1:0]  evt_q[$];
  logic [32:0] rsp_e;
  logic [1:0]  evt_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] arg,
                               input logic [2:0] alen, input logic [2:0] rlen);
    int n;
    n = (alen > 3'd4) ? 4 : int'(alen);
    tx_q.push_back(cmd);
    for (int i = 0; i < n; i++) tx_q.push_back(arg[8*i +: 8]);
    req_cmd     = cmd;
    req_arg     = arg;
    req_arg_len = alen;
    req_rsp_len = rlen;
    req_valid   = 1'b1;
    tick();
    req_valid   = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, input bit toggle);
    int start;
    start = rsp_count;
    for (int i = 0; i < budget && rsp_count == start; i++) begin
      if (toggle) tx_ready = ~tx_ready;
      tick();
    end
    checkOutput("rsp_seen", 32'(rsp_count - start), 32'd1);
  endtask

  task automatic wait_evt(input int budget);
    int start;
    start = evt_count;
    for (int i = 0; i < budget && evt_count == start; i++) tick();
    checkOutput("evt_seen", 32'(evt_count - start), 32'd1);
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("tx_hold_valid", 32'(tx_valid), 32'd1);
        checkOutput("tx_hold_data", 32'(tx_data), 32'(prev_tx));
      end
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) checkOutput("tx_unexpected", 32'(tx_valid), 32'd0);
        else checkOutput("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
        last_hs_cyc = cyc;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_tx    = tx_data;
      if (rsp_valid) begin
        rsp_count++;
        rsp_gap      = cyc - last_hs_cyc;
        last_rsp_cyc = cyc;
        if (rsp_q.size() == 0) checkOutput("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          rsp_e = rsp_q.pop_front();
          checkOutput("rsp_data", rsp_data, rsp_e[31:0]);
          checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(rsp_e[32]));
        end
      end
      if (evt_valid) begin
        evt_count++;
        last_evt_cyc = cyc;
        if (evt_q.size() == 0) checkOutput("evt_unexpected", 32'(evt_valid), 32'd0);
        else begin
          evt_e = evt_q.pop_front();
          checkOutput("evt_code", 32'(evt_code), 32'(evt_e));
        end
      end
    end
  end

  initial begin
    int rx_cyc, gap, rc, ec;

    $display("[TB] reset state");
    tick();
    tick();
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_evt_valid", 32'(evt_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("post_rst_rsp_data", rsp_data, 32'd0);
    checkOutput("post_rst_drop_cnt", 32'(drop_cnt), 32'd0);

    $display("[TB] write-address with stalls");
    tx_ready = 1'b1;
    rsp_q.push_back({1'b0, 32'h0});
    applyStimulus(8'h41, 32'h0000_1234, 3'd2, 3'd0);
    wait_rsp(40, 1'b1);
    checkOutput("rsp_after_last_hs", 32'(rsp_gap), 32'd1);
    tx_ready = 1'b1;
    tick();

    $display("[TB] read-bus single byte");
    rsp_q.push_back({1'b0, 32'h0000_005A});
    applyStimulus(8'h62, 32'h0, 3'd0, 3'd1);
    repeat (9) tick();
    send_rx(8'h5A);
    wait_rsp(10, 1'b0);
    tick();

    $display("[TB] read-address partial reply then timeout");
    rsp_q.push_back({1'b1, 32'h0000_0034});
    applyStimulus(8'h61, 32'h0, 3'd0, 3'd2);
    repeat (3) tick();
    send_rx(8'h34);
    rx_cyc = cyc;
    wait_rsp(TIMEOUT + 10, 1'b0);
    gap = last_rsp_cyc - rx_cyc;
    checkOutput("timeout_gap_in_range", 32'(gap >= TIMEOUT && gap <= TIMEOUT + 2), 32'd1);
    tick();

    $display("[TB] clamped lengths, raw 0x23 in reply");
    rsp_q.push_back({1'b0, 32'h4423_2211});
    applyStimulus(8'h4D, 32'hDEAD_BEEF, 3'd7, 3'd6);
    repeat (7) tick();
    send_rx(8'h11);
    send_rx(8'h22);
    send_rx(8'h23);
    send_rx(8'h44);
    wait_rsp(5, 1'b0);
    checkOutput("no_evt_from_reply", 32'(evt_count), 32'd0);
    tick();

    $display("[TB] events");
    evt_q.push_back(2'd2);
    send_rx(8'h23);
    checkOutput("req_ready_in_evt", 32'(req_ready), 32'd0);
    send_rx(8'h48);
    send_rx(8'h4C);
    send_rx(8'h54);
    wait_evt(5);
    evt_q.push_back(2'd1);
    send_rx(8'h23);
    send_rx(8'h42);
    send_rx(8'h52);
    send_rx(8'h4B);
    wait_evt(5);
    evt_q.push_back(2'd3);
    send_rx(8'h23);
    send_rx(8'h58);
    send_rx(8'h59);
    send_rx(8'h5A);
    wait_evt(5);
    evt_q.push_back(2'd3);
    send_rx(8'h23);
    wait_evt(TIMEOUT + 10);
    tick();

    $display("[TB] dropped bytes");
    send_rx(8'h41);
    exp_drop++;
    tx_ready = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h23;
    rsp_q.push_back({1'b0, 32'h0});
    applyStimulus(8'h73, 32'h0, 3'd0, 3'd0);
    rx_valid = 1'b0;
    exp_drop++;
    send_rx(8'h55);
    exp_drop++;
    tx_ready = 1'b1;
    wait_rsp(10, 1'b0);
    checkOutput("drop_cnt_three", 32'(drop_cnt), 32'(exp_drop));
    tick();
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    repeat (300) tick();
    rx_valid = 1'b0;
    exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
    checkOutput("drop_cnt_saturated", 32'(drop_cnt), 32'(exp_drop));
    tick();

    $display("[TB] reset during argument stall");
    tx_ready = 1'b1;
    applyStimulus(8'h41, 32'hCAFE_F00D, 3'd3, 3'd0);
    tick();
    tx_ready = 1'b0;
    tick();
    tick();
    rc = rsp_count;
    ec = evt_count;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("mid_rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    tx_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checkOutput("mid_rst_release_ready", 32'(req_ready), 32'd1);
    tx_ready = 1'b1;
    repeat (30) tick();
    checkOutput("aborted_no_rsp", 32'(rsp_count - rc), 32'd0);
    checkOutput("aborted_no_evt", 32'(evt_count - ec), 32'd0);

    checkOutput("tx_q_drained", 32'(tx_q.size()), 32'd0);
    checkOutput("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    checkOutput("evt_q_drained", 32'(evt_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
